oser10_sched: RTL and testbench

OSER10_SCHED -- requirements
Module: oser10_sched

---
 rtl/oser10_sched.sv | 130 +++++++++++++
 tb/tb_oser10_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/oser10_sched.sv
// oser10_sched: round-robin scheduler feeding 10-bit words to one OSER10 lane.
// Optional training-word injection is enabled by defining OSER10_SCHED_TRAIN_EN.
module oser10_sched #(
    parameter int         NREQ       = 2,
    parameter logic [9:0] IDLE_WORD  = 10'b1010101010,
    parameter logic [9:0] TRAIN_WORD = 10'b1111100000
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef OSER10_SCHED_TRAIN_EN
    input  logic                train_i,
`endif
    input  logic                en_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [10*NREQ-1:0]  req_data_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic                pclk_o,
    output logic [9:0]          word_o,
    output logic                word_valid_o,
    output logic [NREQ-1:0]     grant_o
);

    typedef enum logic [2:0] {
        PH0, PH1, PH2, PH3, PH4
    } phase_t;

    phase_t          phase_q;
    phase_t          phase_d;
    logic            load;
    logic            train;
    logic            accept;
    logic            found;
    logic [2:0]      ptr_q;
    logic [2:0]      sel_idx;
    logic [NREQ-1:0] sel_oh;
    logic [9:0]      sel_word;
    logic            pclk_q;
    logic [9:0]      word_q;
    logic            wvalid_q;
    logic [NREQ-1:0] grant_q;

`ifdef OSER10_SCHED_TRAIN_EN
    assign train = train_i;
`else
    assign train = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH4;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = PH0;
        unique case (phase_q)
            PH0:     phase_d = PH1;
            PH1:     phase_d = PH2;
            PH2:     phase_d = PH3;
            PH3:     phase_d = PH4;
            PH4:     phase_d = PH0;
            default: phase_d = PH0;
        endcase
    end

    assign load = (phase_q == PH4);

    // Smallest rotated distance past the last owner wins.
    always_comb begin
        int best_d;
        int d;
        sel_oh   = '0;
        sel_idx  = '0;
        sel_word = '0;
        found    = 1'b0;
        best_d   = NREQ;
        d        = 0;
        for (int k = 0; k < NREQ; k++) begin
            d = (k + 2 * NREQ - int'(ptr_q) - 1) % NREQ;
            if (req_valid_i[k] && (d < best_d)) begin
                best_d    = d;
                found     = 1'b1;
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
                sel_idx   = 3'(k);
                sel_word  = req_data_i[10*k +: 10];
            end
        end
    end

    assign accept = found & en_i & ~train;

    assign req_ready_o = (load && accept && !rst_i) ? sel_oh : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pclk_q   <= 1'b0;
            word_q   <= IDLE_WORD;
            wvalid_q <= 1'b0;
            grant_q  <= '0;
            ptr_q    <= 3'(NREQ - 1);
        end else begin
            pclk_q <= load || (phase_q == PH0);
            if (load) begin
                if (train) begin
                    word_q   <= TRAIN_WORD;
                    wvalid_q <= 1'b0;
                    grant_q  <= '0;
                end else if (accept) begin
                    word_q   <= sel_word;
                    wvalid_q <= 1'b1;
                    grant_q  <= sel_oh;
                    ptr_q    <= sel_idx;
                end else begin
                    word_q   <= IDLE_WORD;
                    wvalid_q <= 1'b0;
                    grant_q  <= '0;
                end
            end
        end
    end

    assign pclk_o       = pclk_q;
    assign word_o       = word_q;
    assign word_valid_o = wvalid_q;
    assign grant_o      = grant_q;

endmodule

// File: tb/tb_oser10_sched.sv
// tb_oser10_sched: randomized bench for oser10_sched against a cycle-count
// reference model (load every 5th cycle after release, rotating priority).
module tb_oser10_sched;

    localparam int         NREQ  = 2;
    localparam logic [9:0] IDLE  = 10'b1010101010;
    localparam logic [9:0] TRAIN = 10'b1111100000;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                en_i;
    logic                train_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [10*NREQ-1:0]  req_data_i;
    logic [NREQ-1:0]     req_ready_o;
    logic                pclk_o;
    logic [9:0]          word_o;
    logic                word_valid_o;
    logic [NREQ-1:0]     grant_o;

    always #5 clk_i = ~clk_i;

    oser10_sched #(.NREQ(NREQ)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
`ifdef OSER10_SCHED_TRAIN_EN
        .train_i      (train_i),
`endif
        .en_i         (en_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .pclk_o       (pclk_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .grant_o      (grant_o)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         since;
    int         last;
    int         owner;
    int         mode;
    logic [9:0] m_word;
    logic       m_valid;
    logic       vld [NREQ];
    logic [9:0] dat [NREQ];
    logic       acc [NREQ];

    always_comb begin
        req_valid_i = '0;
        req_data_i  = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_valid_i[k]          = vld[k];
            req_data_i[10*k +: 10]  = dat[k];
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic train_on();
`ifdef OSER10_SCHED_TRAIN_EN
        return train_i;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pick();
        if (rst_i || (since % 5 != 0) || !en_i || train_on())
            return -1;
        for (int i = 1; i <= NREQ; i++) begin
            int k;
            k = (last + i) % NREQ;
            if (vld[k])
                return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        since   = 0;
        last    = NREQ - 1;
        owner   = -1;
        m_word  = IDLE;
        m_valid = 1'b0;
        for (int k = 0; k < NREQ; k++)
            acc[k] = 1'b0;
    endtask

    task automatic step();
        int              p;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_gnt;
        if (rst_i)
            model_reset();
        #1;
        p       = pick();
        exp_rdy = '0;
        if (p >= 0)
            exp_rdy[p] = 1'b1;
        exp_gnt = '0;
        if (owner >= 0)
            exp_gnt[owner] = 1'b1;
        chk("ready", 32'(req_ready_o), 32'(exp_rdy));
        chk("pclk", 32'(pclk_o), 32'((since % 5 == 1) || (since % 5 == 2)));
        chk("word", 32'(word_o), 32'(m_word));
        chk("wvalid", 32'(word_valid_o), 32'(m_valid));
        chk("grant", 32'(grant_o), 32'(exp_gnt));
        for (int k = 0; k < NREQ; k++)
            acc[k] = 1'b0;
        if (!rst_i) begin
            if (since % 5 == 0) begin
                if (train_on()) begin
                    m_word  = TRAIN;
                    m_valid = 1'b0;
                    owner   = -1;
                end else if (p >= 0) begin
                    m_word  = dat[p];
                    m_valid = 1'b1;
                    owner   = p;
                    last    = p;
                    acc[p]  = 1'b1;
                end else begin
                    m_word  = IDLE;
                    m_valid = 1'b0;
                    owner   = -1;
                end
            end
            since++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic update_reqs();
        for (int k = 0; k < NREQ; k++) begin
            if (mode == 0) begin
                vld[k] = 1'b0;
            end else if (mode == 2) begin
                if (vld[k] && acc[k]) begin
                    if ($urandom_range(0, 1) == 0)
                        vld[k] = 1'b0;
                    else
                        dat[k] = 10'($urandom);
                end else if (!vld[k] && $urandom_range(0, 3) == 0) begin
                    vld[k] = 1'b1;
                    dat[k] = 10'($urandom);
                end
            end
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b1;
        train_i = 1'b0;
        mode    = 0;
        for (int k = 0; k < NREQ; k++) begin
            vld[k] = 1'b0;
            dat[k] = '0;
        end
        model_reset();
        @(negedge clk_i);
        repeat (3) step();
        rst_i = 1'b0;

        repeat (12) begin
            step();
            update_reqs();
        end

        mode   = 1;
        dat[0] = 10'h155;
        dat[1] = 10'h2AA;
        vld[0] = 1'b1;
        vld[1] = 1'b1;
        repeat (30) begin
            step();
            update_reqs();
        end

        mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                en_i = ~en_i;
`ifdef OSER10_SCHED_TRAIN_EN
            if ($urandom_range(0, 29) == 0)
                train_i = ~train_i;
`endif
            if (i == 200) begin
                for (int j = 0; j < 5 && (since % 5 != 3); j++) begin
                    step();
                    update_reqs();
                end
                rst_i = 1'b1;
                repeat (3) step();
                rst_i = 1'b0;
            end
            step();
            update_reqs();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
